// File: rtl/jk_write_driver_pkg.sv
// Shared JK excitation codes, FSM state encoding and the per-bit excitation rule
// for the JK latch write driver.
package jk_write_driver_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CHECK = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  // Toggle is never emitted: a transparent latch with J=K=1 oscillates while enabled.
  function automatic logic [1:0] jk_code(input logic q, input logic t);
    logic [1:0] code;
    if (q == t) code = JK_HOLD;
    else if (t) code = JK_SET;
    else        code = JK_RST;
    return (code == JK_TGL) ? JK_HOLD : code;
  endfunction

endpackage

// File: rtl/jk_excite_comb.sv
// Combinational J/K excitation for a word of JK latches: drives each bit
// towards its target value and flags whether any bit still differs.
module jk_excite_comb
  import jk_write_driver_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             any_diff
);

  always_comb begin
    j = '0;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j[i], k[i]} = jk_code(q[i], target[i]);
    end
  end

  assign any_diff = |(q ^ target);

endmodule

// File: rtl/jk_write_driver.sv
// Write-side controller for a bank of level-sensitive JK latches: excite, pulse
// the shared enable, read back, retry on mismatch, then report done/err.
module jk_write_driver
  import jk_write_driver_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EN_CYCLES = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             en_out,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] rd_data
);

  localparam int CNT_W   = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   target;
  logic [CNT_W-1:0]   en_cnt;
  logic [RETRY_W-1:0] retry;

  logic [WIDTH-1:0]   exc_j;
  logic [WIDTH-1:0]   exc_k;
  logic               any_diff;
  logic               accept;
  logic               match;
  logic               pulse_last;
  logic               can_retry;

  jk_excite_comb #(.WIDTH(WIDTH)) u_excite (
    .q        (q_in),
    .target   (target),
    .j        (exc_j),
    .k        (exc_k),
    .any_diff (any_diff)
  );

  assign req_ready  = (state == ST_IDLE) && reset;
  assign accept     = req_valid && req_ready;
  assign match      = (q_in == target);
  assign pulse_last = (en_cnt == CNT_W'(EN_CYCLES - 1));
  assign can_retry  = (retry < RETRY_W'(MAX_RETRY));

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept) next_state = ST_SETUP;
      ST_SETUP: next_state = any_diff ? ST_PULSE : ST_CHECK;
      ST_PULSE: if (pulse_last) next_state = ST_HOLD;
      ST_HOLD:  next_state = ST_CHECK;
      ST_CHECK: begin
        if (match)          next_state = ST_RESP;
        else if (can_retry) next_state = ST_SETUP;
        else                next_state = ST_RESP;
      end
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Control counters and captured target
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target <= '0;
      retry  <= '0;
      en_cnt <= '0;
    end else begin
      if (accept) target <= req_data;
      if (accept)
        retry <= '0;
      else if ((state == ST_CHECK) && !match && can_retry)
        retry <= retry + RETRY_W'(1);
      if (state == ST_PULSE) en_cnt <= en_cnt + CNT_W'(1);
      else                   en_cnt <= '0;
    end
  end

  // Registered latch drive: J/K loaded in SETUP, held through PULSE and HOLD, zero elsewhere
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      j_out   <= '0;
      k_out   <= '0;
      en_out  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rd_data <= '0;
    end else begin
      en_out <= (next_state == ST_PULSE);
      case (state)
        ST_SETUP: begin
          j_out <= exc_j;
          k_out <= exc_k;
        end
        ST_PULSE: begin
          j_out <= j_out;
          k_out <= k_out;
        end
        default: begin
          j_out <= '0;
          k_out <= '0;
        end
      endcase
      if (state == ST_CHECK) rd_data <= q_in;
      done <= (next_state == ST_RESP);
      err  <= (next_state == ST_RESP) && !match;
    end
  end

endmodule

// File: tb/tb_jk_write_driver.sv
// Bench for jk_write_driver: two driver instances (enable width 1 and 3) each
// writing a bank of behavioural JK latches, with directed and random writes.
module tb_jk_write_driver;

  localparam int MAXR = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid [2] = '{1'b0, 1'b0};
  logic [7:0] req_data  [2] = '{8'h00, 8'h00};
  logic [7:0] stuck     [2] = '{8'h00, 8'h00};
  logic       req_ready [2];
  logic       en_out    [2];
  logic       done      [2];
  logic       err       [2];
  logic [7:0] q_in      [2];
  logic [7:0] j_out     [2];
  logic [7:0] k_out     [2];
  logic [7:0] rd_data   [2];

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] m_q [2];

  // reference model results for the transaction in progress
  int         e_lat, e_pulses;
  bit         e_err;
  logic [7:0] e_rd;
  logic [7:0] e_j [4];
  logic [7:0] e_k [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] lq = 8'h00;

    jk_write_driver #(.WIDTH(8), .EN_CYCLES((g == 0) ? 1 : 3), .MAX_RETRY(MAXR)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_data  (req_data[g]),
      .q_in      (q_in[g]),
      .j_out     (j_out[g]),
      .k_out     (k_out[g]),
      .en_out    (en_out[g]),
      .done      (done[g]),
      .err       (err[g]),
      .rd_data   (rd_data[g])
    );

    // transparent JK latch bank; stuck bits are forced low inside the latch
    always @(en_out[g] or j_out[g] or k_out[g] or stuck[g]) begin
      if (en_out[g]) lq = (lq & ~k_out[g]) | j_out[g];
      lq = lq & ~stuck[g];
    end
    assign q_in[g] = lq;
  end

  function automatic int enc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, i, act, exp);
    end
  endtask

  // Latch bank behaviour: each write attempt leaves the bank at target with stuck bits low.
  task automatic model_txn(input logic [7:0] q0, input logic [7:0] t, input logic [7:0] sk, input int en);
    logic [7:0] qv;
    int tries;
    qv = q0; tries = 0;
    e_pulses = 0; e_lat = 1; e_err = 0;
    forever begin
      if (qv != t) begin
        e_j[e_pulses] = t & ~qv;
        e_k[e_pulses] = ~t & qv;
        e_pulses++;
        qv = t & ~sk;
        e_lat += en + 1;
      end
      e_lat += 1;
      if (qv == t) break;
      if (tries == MAXR) begin e_err = 1; break; end
      tries++;
      e_lat += 1;
    end
    e_rd = qv;
    e_lat += 1;
  endtask

  task automatic run_txn(input int i, input logic [7:0] t, input bit hold, input logic [7:0] nxt,
                         output int lat, output bit er, output logic [7:0] rd, output int pulses);
    int cyc, en_cyc;
    bit seen_done;
    logic prev_en;
    model_txn(m_q[i], t, stuck[i], enc(i));
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_data[i]  = t;
    chk("ready_before_accept", i, 32'(req_ready[i]), 1);
    @(posedge clk); #1;
    if (hold) req_data[i] = nxt;
    else      req_valid[i] = 1'b0;
    cyc = 1; pulses = 0; en_cyc = 0; prev_en = 1'b0; seen_done = 0;
    lat = 0; er = 0; rd = 8'h00;
    forever begin
      if (en_out[i]) begin
        if (!prev_en) pulses++;
        en_cyc++;
        chk("jk_not_toggle", i, 32'(j_out[i] & k_out[i]), 0);
        if (pulses <= e_pulses) begin
          chk("j_during_pulse", i, 32'(j_out[i]), 32'(e_j[pulses-1]));
          chk("k_during_pulse", i, 32'(k_out[i]), 32'(e_k[pulses-1]));
        end
      end
      prev_en = en_out[i];
      chk("ready_low_busy", i, 32'(req_ready[i]), 0);
      if (done[i]) begin
        seen_done = 1; lat = cyc; er = err[i]; rd = rd_data[i];
        break;
      end
      if (cyc >= 80) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", i, 32'(seen_done), 1);
    chk("en_cycles", i, en_cyc, pulses * enc(i));
    @(posedge clk); #1;
    chk("done_one_cycle", i, 32'(done[i]), 0);
    chk("ready_after_done", i, 32'(req_ready[i]), 1);
    m_q[i] = e_rd;
  endtask

  typedef struct {
    int         inst;
    logic [7:0] t;
    logic [7:0] sk;
    bit         hold;
    logic [7:0] nxt;
    int         lat;
    bit         er;
    logic [7:0] rd;
    int         pulses;
  } vec_t;

  initial begin
    vec_t vt [8];
    int lat, pulses, wcyc;
    bit er;
    logic [7:0] rd;

    vt[0] = '{0, 8'hA5, 8'h00, 0, 8'h00,  5, 0, 8'hA5, 1};
    vt[1] = '{0, 8'h5A, 8'h00, 0, 8'h00,  5, 0, 8'h5A, 1};
    vt[2] = '{0, 8'h5A, 8'h00, 0, 8'h00,  3, 0, 8'h5A, 0};
    vt[3] = '{0, 8'h00, 8'h00, 0, 8'h00,  5, 0, 8'h00, 1};
    vt[4] = '{0, 8'h08, 8'h08, 0, 8'h00, 13, 1, 8'h00, 3};
    vt[5] = '{0, 8'h3C, 8'h00, 0, 8'h00,  5, 0, 8'h3C, 1};
    vt[6] = '{1, 8'h96, 8'h00, 1, 8'h69,  7, 0, 8'h96, 1};
    vt[7] = '{1, 8'h69, 8'h00, 0, 8'h00,  7, 0, 8'h69, 1};

    m_q[0] = 8'h00; m_q[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_en", i, 32'(en_out[i]), 0);
      chk("rst_j", i, 32'(j_out[i]), 0);
      chk("rst_k", i, 32'(k_out[i]), 0);
      chk("rst_done", i, 32'(done[i]), 0);
      chk("rst_err", i, 32'(err[i]), 0);
      chk("rst_rd", i, 32'(rd_data[i]), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) chk("ready_after_reset", i, 32'(req_ready[i]), 1);

    for (int v = 0; v < 8; v++) begin
      stuck[vt[v].inst] = vt[v].sk;
      m_q[vt[v].inst] = m_q[vt[v].inst] & ~vt[v].sk;
      run_txn(vt[v].inst, vt[v].t, vt[v].hold, vt[v].nxt, lat, er, rd, pulses);
      chk("vec_latency", v, lat, vt[v].lat);
      chk("vec_err", v, 32'(er), 32'(vt[v].er));
      chk("vec_rd", v, 32'(rd), 32'(vt[v].rd));
      chk("vec_pulses", v, pulses, vt[v].pulses);
    end
    stuck[0] = 8'h00;

    // reset asserted while the enable pulse is high
    @(negedge clk);
    req_valid[0] = 1'b1; req_data[0] = 8'hFF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wcyc = 0;
    while (!en_out[0] && wcyc < 10) begin
      @(posedge clk); #1;
      wcyc++;
    end
    chk("pulse_reached", 0, 32'(en_out[0]), 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_en", 0, 32'(en_out[0]), 0);
    chk("abort_j", 0, 32'(j_out[0]), 0);
    chk("abort_k", 0, 32'(k_out[0]), 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 0, 32'(done[0]), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ready_after_abort", 0, 32'(req_ready[0]), 1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("abort_no_done_late", 0, 32'(done[0]), 0);
    end
    m_q[0] = 8'hFF;
    run_txn(0, 8'h81, 0, 8'h00, lat, er, rd, pulses);
    chk("post_abort_lat", 0, lat, 5);
    chk("post_abort_err", 0, 32'(er), 0);
    chk("post_abort_rd", 0, 32'(rd), 8'h81);

    // random writes against the reference model
    for (int n = 0; n < 30; n++) begin
      int i;
      logic [7:0] t, sk;
      i  = $urandom_range(0, 1);
      sk = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      stuck[i] = sk;
      m_q[i] = m_q[i] & ~sk;
      t = ($urandom_range(0, 3) == 0) ? m_q[i] : 8'($urandom);
      run_txn(i, t, 0, 8'h00, lat, er, rd, pulses);
      chk("rnd_latency", i, lat, e_lat);
      chk("rnd_err", i, 32'(er), 32'(e_err));
      chk("rnd_rd", i, 32'(rd), 32'(e_rd));
      chk("rnd_pulses", i, pulses, e_pulses);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
